// File: rtl/clk_div_bank_pkg.sv
// clk_div_bank_pkg: shared constants and helpers for the clock-divider bank.
// System clock rate, default counter width, half-period calculator and
// channel-index width helper.
package clk_div_bank_pkg;

    localparam int unsigned SYS_CLK_HZ = 50000000;
    localparam int          CNT_W_DEF  = 27;

    // Half-period count minus 1 for a target output frequency.
    function automatic int unsigned half_from_hz(input int unsigned f_hz);
        return (SYS_CLK_HZ / f_hz) / 2 - 1;
    endfunction

    // Width of a channel index; at least one bit even for a single channel.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel -- counter, shadow/active limits,
// registered square-wave output and toggle strobe.
// CLK_DIV_BANK_DUTY_EN: separate high/low phase limits selected by 'hi'.
module clk_div_chan #(
    parameter int          CNT_W    = 27,
    parameter int unsigned DEF_HALF = 24999
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic             hi,
    input  logic [CNT_W-1:0] half,
    output logic             out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] DEF_LIM = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lim;
    logic             run;   // set once the first enabled edge has armed the counter
    logic             load;  // shadow -> active transfer this edge

    // Active limits may only change while the counter sits at 0 (toggle,
    // idle, arming or sync), so a running phase is never shortened.
    assign load = sync || !en || !run || (cnt == lim);

`ifdef CLK_DIV_BANK_DUTY_EN
    logic [CNT_W-1:0] sh_hi, sh_lo, act_hi, act_lo;
    logic [CNT_W-1:0] sh_hi_nxt, sh_lo_nxt;

    // Next shadow values; a same-cycle write is what gets loaded.
    always_comb begin
        sh_hi_nxt = (we && hi)  ? half : sh_hi;
        sh_lo_nxt = (we && !hi) ? half : sh_lo;
    end

    // Shadow and active limit registers for both phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_hi  <= DEF_LIM;
            sh_lo  <= DEF_LIM;
            act_hi <= DEF_LIM;
            act_lo <= DEF_LIM;
        end else begin
            sh_hi <= sh_hi_nxt;
            sh_lo <= sh_lo_nxt;
            if (load) begin
                act_hi <= sh_hi_nxt;
                act_lo <= sh_lo_nxt;
            end
        end
    end

    assign lim = out ? act_hi : act_lo;
`else
    logic [CNT_W-1:0] sh, act, sh_nxt;
    logic             unused_hi;

    assign unused_hi = hi;

    // Next shadow value; a same-cycle write is what gets loaded.
    always_comb begin
        sh_nxt = we ? half : sh;
    end

    // Single shadow/active limit shared by both phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= DEF_LIM;
            act <= DEF_LIM;
        end else begin
            sh <= sh_nxt;
            if (load) act <= sh_nxt;
        end
    end

    assign lim = act;
`endif

    // Counter/output sequencing: sync and disable clear, first enabled edge
    // arms, then count to lim and toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            out  <= 1'b0;
            tick <= 1'b0;
            run  <= 1'b0;
        end else if (sync) begin
            cnt  <= '0;
            out  <= 1'b0;
            tick <= 1'b0;
            run  <= en;
        end else if (!en) begin
            cnt  <= '0;
            out  <= 1'b0;
            tick <= 1'b0;
            run  <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            tick <= 1'b0;
            run  <= 1'b1;
        end else if (cnt == lim) begin
            cnt  <= '0;
            out  <= ~out;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: N_CH independent programmable clock-enable / square-wave
// generators with a shared phase-aligning sync.
// CLK_DIV_BANK_DUTY_EN: per-channel high/low phase lengths (cfg_hi selects).
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int          N_CH     = 4,
    parameter int          CNT_W    = CNT_W_DEF,
    parameter int unsigned DEF_HALF = 24999,
    localparam int         CH_W     = ch_idx_w(N_CH)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic             cfg_hi,
    input  logic [CNT_W-1:0] cfg_half,
    output logic [N_CH-1:0]  out,
    output logic [N_CH-1:0]  tick
);

    // Write decode: an index with no matching channel simply selects nothing.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic we_i;
        assign we_i = cfg_we && (int'(cfg_ch) == i);

        clk_div_chan #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en[i]),
            .sync  (sync),
            .we    (we_i),
            .hi    (cfg_hi),
            .half  (cfg_half),
            .out   (out[i]),
            .tick  (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed + random stimulus against an event-time model
// (absolute next-toggle cycle per channel).
module tb_clk_div_bank;

    localparam int N   = 5;
    localparam int CW  = 8;
    localparam int DH  = 3;
    localparam int CHW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   en = '0;
    logic           sync = 1'b0;
    logic           cfg_we = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic           cfg_hi = 1'b0;
    logic [CW-1:0]  cfg_half = '0;
    logic [N-1:0]   out, tick;

    always #5 clk = ~clk;

    clk_div_bank #(.N_CH(N), .CNT_W(CW), .DEF_HALF(DH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_hi(cfg_hi), .cfg_half(cfg_half),
        .out(out), .tick(tick)
    );

    int errors = 0;
    int checks = 0;
    int t = 0;

    // Model state: phase level, strobe, armed flag, absolute cycle of next toggle.
    int m_out[N], m_tick[N], m_run[N], m_next[N];
    int a_hi[N], a_lo[N], s_hi[N], s_lo[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_out[i] = 0; m_tick[i] = 0; m_run[i] = 0; m_next[i] = 0;
            a_hi[i] = DH; a_lo[i] = DH; s_hi[i] = DH; s_lo[i] = DH;
        end
    endtask

    // Phase length (minus 1) of the phase just entered.
    function automatic int phase_lim(input int i);
        return m_out[i] ? a_hi[i] : a_lo[i];
    endfunction

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (cfg_we && int'(cfg_ch) == i) begin
`ifdef CLK_DIV_BANK_DUTY_EN
                if (cfg_hi) s_hi[i] = int'(cfg_half);
                else        s_lo[i] = int'(cfg_half);
`else
                s_hi[i] = int'(cfg_half);
                s_lo[i] = int'(cfg_half);
`endif
            end
            if (sync) begin
                m_out[i] = 0; m_tick[i] = 0;
                a_hi[i] = s_hi[i]; a_lo[i] = s_lo[i];
                m_run[i] = int'(en[i]);
                m_next[i] = t + a_lo[i] + 1;
            end else if (!en[i]) begin
                m_out[i] = 0; m_tick[i] = 0; m_run[i] = 0;
                a_hi[i] = s_hi[i]; a_lo[i] = s_lo[i];
            end else if (m_run[i] == 0) begin
                m_run[i] = 1; m_tick[i] = 0;
                a_hi[i] = s_hi[i]; a_lo[i] = s_lo[i];
                m_next[i] = t + a_lo[i] + 1;
            end else if (t == m_next[i]) begin
                m_out[i] = 1 - m_out[i]; m_tick[i] = 1;
                a_hi[i] = s_hi[i]; a_lo[i] = s_lo[i];
                m_next[i] = t + phase_lim(i) + 1;
            end else begin
                m_tick[i] = 0;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_out();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_out[i] != 0);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_tick();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_tick[i] != 0);
        return v;
    endfunction

    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            t++;
            #1;
            chk($sformatf("out@%0d", t), 32'(out), 32'(exp_out()));
            chk($sformatf("tick@%0d", t), 32'(tick), 32'(exp_tick()));
        end
    endtask

    task automatic wr(input int ch, input int hi, input int half);
        cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_hi = hi[0]; cfg_half = CW'(half);
        cyc();
        cfg_we = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // ch0 at default half 3: first toggle 4 edges after the arming edge
        en[0] = 1'b1;
        cyc();
        cyc(4);
        chk("ch0_first_toggle_out", 32'(out[0]), 32'd1);
        chk("ch0_first_toggle_tick", 32'(tick[0]), 32'd1);
        cyc(20);

        // ch1 running at 3, reprogrammed to 9 mid-phase
        en[1] = 1'b1;
        cyc(6);
        wr(1, 0, 9);
        cyc(40);

        // ch2 at half 0: clk/2, tick stuck high; then drop enable
        wr(2, 0, 0);
        en[2] = 1'b1;
        cyc();
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("ch2_tick_high", 32'(tick[2]), 32'd1);
        end
        en[2] = 1'b0;
        cyc();
        chk("ch2_off_out", 32'(out[2]), 32'd0);
        chk("ch2_off_tick", 32'(tick[2]), 32'd0);

        // ch0 and ch3 started two cycles apart, then aligned by sync
        en = '0;
        cyc(2);
        en[0] = 1'b1;
        cyc(2);
        en[3] = 1'b1;
        cyc(3);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        cyc(3);
        chk("sync_pre_tick", 32'({tick[3], tick[0]}), 32'd0);
        cyc();
        chk("sync_aligned_tick", 32'({tick[3], tick[0]}), 32'd3);
        chk("sync_aligned_out", 32'({out[3], out[0]}), 32'd3);
        cyc(10);

        // ch0 high=1, low=5 (duty build) or 50 % at 5 (single-limit build)
        wr(0, 1, 1);
        wr(0, 0, 5);
        cyc(30);

        // out-of-range channel index writes nothing
        wr(N, 0, 0);
        wr(7, 1, 0);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        cyc(20);

        // sync and write in the same cycle
        en = 5'b11111;
        cfg_we = 1'b1; cfg_ch = 3'd4; cfg_hi = 1'b0; cfg_half = 8'd2; sync = 1'b1;
        cyc();
        cfg_we = 1'b0; sync = 1'b0;
        cyc(12);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) en = N'($urandom);
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_ch   = CHW'($urandom_range(0, 7));
            cfg_hi   = 1'($urandom);
            cfg_half = CW'($urandom_range(0, 6));
            sync     = ($urandom_range(0, 30) == 0);
            cyc();
        end
        cfg_we = 1'b0; sync = 1'b0;
        en = 5'b11111;
        cyc(15);

        // asynchronous reset mid-count
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_out", 32'(out), 32'd0);
        chk("async_rst_tick", 32'(tick), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_out", 32'(out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of independent clock-enable/square-wave generators driven from the single system clock. Each channel has a runtime-programmable half-period, a per-channel enable and a one-cycle `tick` strobe, replacing fixed hard-coded divide ratios. All channels can be restarted phase-aligned with one `sync` pulse. Sits beside the system clock input and feeds UART baud, PWM, scan and timebase logic.

## Interface
- `N_CH`, 4, number of channels (1..16)
- `CNT_W`, 27, counter and half-period width; must hold 24999999 for 1 Hz from 50 MHz
- `DEF_HALF`, 24999, reset half-period value (minus 1) loaded into every channel; 1 kHz at 50 MHz

- `clk` in 1: system clock, single clock domain
- `rst_n` in 1: asynchronous, active-low reset
- `en` in N_CH: per-channel run enable, level
- `sync` in 1: one-cycle pulse; restart all channels aligned
- `cfg_we` in 1: configuration write strobe
- `cfg_ch` in $clog2(N_CH) (min 1): target channel
- `cfg_hi` in 1: with duty feature, 1 selects high-phase count, 0 low-phase; ignored otherwise
- `cfg_half` in CNT_W: half-period count minus 1
- `out` out N_CH: divided square wave per channel
- `tick` out N_CH: one-cycle pulse on every `out` toggle

## Operation
- Reset: `out`=0, `tick`=0, counters 0, shadow and active limits = `DEF_HALF`.
- Per channel, while `en[i]`=1: `cnt` increments each clock; when `cnt == lim`, `cnt`←0, `out[i]` toggles, `tick[i]`=1 for that cycle only.
- `lim` = active high count when `out[i]`=1, active low count when `out[i]`=0. Without duty feature both equal one value: period = 2·(half+1) cycles, 50 % duty.
- `cfg_half`=0: `out` toggles every cycle (clk/2), `tick` held high while enabled.
- `cfg_we`: writes shadow register of `cfg_ch`. Out-of-range `cfg_ch` (≥N_CH): write ignored.
- Shadow→active transfer: at that channel's next toggle (glitch-free, current phase never shortened), or immediately if `en[i]`=0, or on `sync`.
- `en[i]`=0: `cnt`←0, `out[i]`←0, `tick[i]`=0 from the next clock; counter holds. Re-enable restarts from `cnt`=0, low phase.
- `sync`: all channels `cnt`←0, `out`←0, `tick`←0, shadow→active, regardless of `en`.
- `sync` and `cfg_we` same cycle: written value lands in shadow and is loaded as active in the same edge (write wins).
- Counter never exceeds `lim`; if active limit changes below `cnt` it cannot, since change only occurs at `cnt`=0.

## Timing
- All outputs registered; no combinational path from any input to `out`/`tick`.
- `en[i]` first sampled high at edge t: first toggle of `out[i]` and `tick[i]` at edge t+lim+1.
- `cfg_we` at edge t: shadow valid after t; active takes effect at next toggle edge.
- `sync` at edge t: outputs 0 after t; first toggle at t+lim+1 for every enabled channel — all equal-`lim` channels toggle on the same edge.
- `rst_n` assertion mid-count: immediate asynchronous clear to reset values; release synchronous to `clk`.

## Configuration
- `CLK_DIV_BANK_DUTY_EN` defined: separate high and low active/shadow registers per channel, selected by `cfg_hi`; high phase lasts high+1 cycles, low phase low+1 cycles.
- Undefined: one limit per channel, `cfg_hi` ignored, writes update the single limit; 50 % duty only. Port list identical in both builds.

## Structure
- Package `clk_div_bank_pkg`: `SYS_CLK_HZ` = 50000000, default `CNT_W`, helper function half-period from target Hz ((SYS_CLK_HZ/f)/2−1), channel-index width.
- Sub-module `clk_div_chan`: one channel (counter, shadow/active limits, out, tick); top is `N_CH` generate instances plus config decode.

## Test plan
- Reset, then `en`=1 on ch0 with DEF_HALF=3 -> `out[0]` toggles every 4 cycles, period 8, `tick[0]` single-cycle at each toggle.
- Write ch1 `cfg_half`=9 mid-phase while running at 3 -> current phase completes at 4 cycles, following phases 10 cycles.
- `cfg_half`=0 on ch2 -> `out[2]` = clk/2, `tick[2]` constantly 1; drop `en[2]` -> `out`,`tick` 0 next cycle.
- Ch0 half 3, ch3 half 3 started 2 cycles apart, then `sync` -> both toggle on the same edge 4 cycles after `sync`.
- Duty build: ch0 high=1, low=5 -> out high 2 cycles, low 6 cycles; non-duty build same writes -> 50 % with last value 5.
- `cfg_ch`=N_CH write with `cfg_half`=0 -> no channel changes; `rst_n` low mid-count -> all outputs 0 asynchronously.
